// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard control unit:
//   state_e  - FSM encodings (RUN / MD_WAIT / MEM_WAIT; 2'b11 is illegal)
//   ctrl_t   - bundle of pipeline-register load enables, bubble (flush)
//              requests and the mul/div start pulse
//   CTRL_*   - canned control words for each hazard response
//   ZERO_REG - architectural x0, which never creates a data dependency
//   reg_hit  - helper: does a used source register match a destination
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MD_WAIT  = 2'b01,
    MEM_WAIT = 2'b10
  } state_e;

  // Bit order (MSB first): pc_write, if_id_write, id_ex_write, ex_mem_write,
  // if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, md_start.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
    logic md_start;
  } ctrl_t;

  // x0 is hard-wired to zero; a load "into" x0 never needs a stall.
  localparam logic [4:0] ZERO_REG = 5'd0;

  // Free-running pipeline: every register loads, no bubbles.
  localparam ctrl_t CTRL_RUN       = 9'b1111_0000_0;
  // Whole pipeline frozen while data memory is busy; MEM/WB gets a NOP so
  // the stalled access does not retire twice.
  localparam ctrl_t CTRL_MEM_HOLD  = 9'b0000_0001_0;
  // Front end frozen behind a multi-cycle op; EX/MEM receives NOPs until
  // the result is ready.
  localparam ctrl_t CTRL_MD_HOLD   = 9'b0001_0010_0;
  // Taken branch: squash the two wrong-path instructions, PC takes target.
  localparam ctrl_t CTRL_BRANCH    = 9'b1111_1100_0;
  // Load-use: hold IF/ID and PC one cycle, send a NOP into EX.
  localparam ctrl_t CTRL_LOAD_USE  = 9'b0011_0100_0;
  // Reset: nothing loads and every stage holds a bubble.
  localparam ctrl_t CTRL_RESET     = 9'b0000_1111_0;

  function automatic logic reg_hit(input logic [4:0] rd,
                                   input logic [4:0] rs,
                                   input logic       used);
    return used && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_control_unit_if
// Groups the pipeline status inputs and the control outputs of the hazard
// unit. Parameter CNT_W sizes the two performance counters.
//   master : the hazard control unit (reads status, drives controls)
//   slave  : the pipeline datapath (drives status, reads controls)
// -----------------------------------------------------------------------------
interface hazard_control_unit_if #(parameter int CNT_W = 16);

  // Pipeline status
  logic [4:0]       IF_ID_RS1;
  logic [4:0]       IF_ID_RS2;
  logic             ID_USES_RS1;
  logic             ID_USES_RS2;
  logic [4:0]       ID_EX_RD;
  logic             ID_EX_MemRead;
  logic             ID_EX_IsMD;
  logic             MD_DONE;
  logic             EX_BranchTaken;
  logic             MEM_Req;
  logic             MEM_Ready;

  // Controls
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             ID_EX_Write;
  logic             EX_MEM_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             EX_MEM_Flush;
  logic             MEM_WB_Flush;
  logic             MD_START;
  logic [1:0]       STATE;
  logic [CNT_W-1:0] STALL_CNT;
  logic [CNT_W-1:0] FLUSH_CNT;

  modport master (
    input  IF_ID_RS1, IF_ID_RS2, ID_USES_RS1, ID_USES_RS2, ID_EX_RD,
           ID_EX_MemRead, ID_EX_IsMD, MD_DONE, EX_BranchTaken, MEM_Req,
           MEM_Ready,
    output PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush,
           ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush, MD_START, STATE,
           STALL_CNT, FLUSH_CNT
  );

  modport slave (
    output IF_ID_RS1, IF_ID_RS2, ID_USES_RS1, ID_USES_RS2, ID_EX_RD,
           ID_EX_MemRead, ID_EX_IsMD, MD_DONE, EX_BranchTaken, MEM_Req,
           MEM_Ready,
    input  PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush,
           ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush, MD_START, STATE,
           STALL_CNT, FLUSH_CNT
  );

endinterface

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, counts on rising edge
//   rst_n : asynchronous active-low clear
//   inc   : count this cycle
//   count : current value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
// Stall / flush controller for a 5-stage pipeline with a multi-cycle mul/div
// unit and a variable-latency data memory.
//   clk   : clock
//   rst_n : asynchronous active-low reset; while low, controls are forced to
//           the reset word (nothing loads, all stages flushed)
//   hz    : hazard_control_unit_if.master - pipeline status in, controls,
//           FSM state and stall/flush counters out
// Priority: memory wait > mul/div > taken branch > load-use.
// -----------------------------------------------------------------------------
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_control_unit_if.master hz
);

  state_e state;
  state_e state_nxt;
  logic   md_issued;
  logic   md_issued_nxt;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;
  logic   mem_stall;
  logic   load_use;

  assign mem_stall = hz.MEM_Req && !hz.MEM_Ready;

  assign load_use = hz.ID_EX_MemRead && (hz.ID_EX_RD != ZERO_REG) &&
                    (reg_hit(hz.ID_EX_RD, hz.IF_ID_RS1, hz.ID_USES_RS1) ||
                     reg_hit(hz.ID_EX_RD, hz.IF_ID_RS2, hz.ID_USES_RS2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      md_issued <= 1'b0;
    end else begin
      state     <= state_nxt;
      md_issued <= md_issued_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ctrl      = CTRL_RUN;
    state_nxt = state;

    if (mem_stall) begin
      ctrl      = CTRL_MEM_HOLD;
      state_nxt = MEM_WAIT;
    end else begin
      case (state)
        // The memory-release cycle is no longer frozen, so it resolves the
        // held lower-priority hazards exactly like RUN does.
        RUN, MEM_WAIT: begin
          state_nxt = RUN;
          if (hz.ID_EX_IsMD && !md_issued) begin
            ctrl          = CTRL_MD_HOLD;
            ctrl.md_start = 1'b1;
            if (hz.MD_DONE) begin
              // Result already available: release in the start cycle.
              ctrl          = CTRL_RUN;
              ctrl.md_start = 1'b1;
            end else begin
              state_nxt = MD_WAIT;
            end
          end else if (hz.EX_BranchTaken) begin
            ctrl = CTRL_BRANCH;
          end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
          end
        end
        MD_WAIT: begin
          if (hz.MD_DONE) begin
            state_nxt = RUN;
          end else begin
            ctrl = CTRL_MD_HOLD;
          end
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // The op in EX is "issued" from its start pulse until ID/EX reloads with
  // a new instruction; that blocks a second start for the same op.
  always_comb begin
    md_issued_nxt = md_issued;
    if (ctrl.id_ex_write) begin
      md_issued_nxt = 1'b0;
    end else if (ctrl.md_start) begin
      md_issued_nxt = 1'b1;
    end
  end

  // Reset overrides the controls combinationally so the pipeline is safe
  // even before the first clock edge.
  assign ctrl_out = rst_n ? ctrl : CTRL_RESET;

  assign hz.PC_Write     = ctrl_out.pc_write;
  assign hz.IF_ID_Write  = ctrl_out.if_id_write;
  assign hz.ID_EX_Write  = ctrl_out.id_ex_write;
  assign hz.EX_MEM_Write = ctrl_out.ex_mem_write;
  assign hz.IF_ID_Flush  = ctrl_out.if_id_flush;
  assign hz.ID_EX_Flush  = ctrl_out.id_ex_flush;
  assign hz.EX_MEM_Flush = ctrl_out.ex_mem_flush;
  assign hz.MEM_WB_Flush = ctrl_out.mem_wb_flush;
  assign hz.MD_START     = ctrl_out.md_start;
  assign hz.STATE        = state;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rst_n && !ctrl_out.pc_write),
    .count (hz.STALL_CNT)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl_out.if_id_flush || ctrl_out.id_ex_flush),
    .count (hz.FLUSH_CNT)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
// Directed test of hazard_control_unit. A 16-bit-counter instance covers the
// hazard responses; a 2-bit-counter instance covers counter saturation.
// Control word layout in expected constants (MSB first):
//   PC_Write IF_ID_Write ID_EX_Write EX_MEM_Write |
//   IF_ID_Flush ID_EX_Flush EX_MEM_Flush MEM_WB_Flush | MD_START
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] C_DEF = 32'b1111_0000_0;
  localparam logic [31:0] C_RST = 32'b0000_1111_0;
  localparam logic [31:0] C_LU  = 32'b0011_0100_0;
  localparam logic [31:0] C_BR  = 32'b1111_1100_0;
  localparam logic [31:0] C_MDS = 32'b0001_0010_1;
  localparam logic [31:0] C_MDW = 32'b0001_0010_0;
  localparam logic [31:0] C_MEM = 32'b0000_0001_0;

  hazard_control_unit_if #(.CNT_W(16)) hz  ();
  hazard_control_unit_if #(.CNT_W(2))  hz2 ();

  hazard_control_unit #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  hazard_control_unit #(.CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz2)
  );

  always #5 clk = ~clk;

  logic [31:0] ctl, ctl2, state, stall, flush, stall2, flush2;
  assign ctl    = {23'd0, hz.PC_Write, hz.IF_ID_Write, hz.ID_EX_Write,
                   hz.EX_MEM_Write, hz.IF_ID_Flush, hz.ID_EX_Flush,
                   hz.EX_MEM_Flush, hz.MEM_WB_Flush, hz.MD_START};
  assign ctl2   = {23'd0, hz2.PC_Write, hz2.IF_ID_Write, hz2.ID_EX_Write,
                   hz2.EX_MEM_Write, hz2.IF_ID_Flush, hz2.ID_EX_Flush,
                   hz2.EX_MEM_Flush, hz2.MEM_WB_Flush, hz2.MD_START};
  assign state  = {30'd0, hz.STATE};
  assign stall  = {16'd0, hz.STALL_CNT};
  assign flush  = {16'd0, hz.FLUSH_CNT};
  assign stall2 = {30'd0, hz2.STALL_CNT};
  assign flush2 = {30'd0, hz2.FLUSH_CNT};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.IF_ID_RS1      = 5'd0;
    hz.IF_ID_RS2      = 5'd0;
    hz.ID_USES_RS1    = 1'b0;
    hz.ID_USES_RS2    = 1'b0;
    hz.ID_EX_RD       = 5'd0;
    hz.ID_EX_MemRead  = 1'b0;
    hz.ID_EX_IsMD     = 1'b0;
    hz.MD_DONE        = 1'b0;
    hz.EX_BranchTaken = 1'b0;
    hz.MEM_Req        = 1'b0;
    hz.MEM_Ready      = 1'b0;
  endtask

  task automatic idle2();
    hz2.IF_ID_RS1      = 5'd0;
    hz2.IF_ID_RS2      = 5'd0;
    hz2.ID_USES_RS1    = 1'b0;
    hz2.ID_USES_RS2    = 1'b0;
    hz2.ID_EX_RD       = 5'd0;
    hz2.ID_EX_MemRead  = 1'b0;
    hz2.ID_EX_IsMD     = 1'b0;
    hz2.MD_DONE        = 1'b0;
    hz2.EX_BranchTaken = 1'b0;
    hz2.MEM_Req        = 1'b0;
    hz2.MEM_Ready      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    idle2();

    // Reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst_ctl",   ctl,   C_RST);
    check("rst_state", state, 32'd0);
    check("rst_stall", stall, 32'd0);
    check("rst_flush", flush, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("idle_ctl",   ctl,   C_DEF);
    check("idle_state", state, 32'd0);
    tick();

    // Load x5 in EX, ID reads RS1=x5.
    hz.ID_EX_RD = 5'd5; hz.ID_EX_MemRead = 1'b1;
    hz.IF_ID_RS1 = 5'd5; hz.ID_USES_RS1 = 1'b1;
    #1 check("lu_rs1_ctl", ctl, C_LU);
    tick();
    check("lu_rs1_stall", stall, 32'd1);
    check("lu_rs1_flush", flush, 32'd1);

    // RS2 matches but is not read: no hazard.
    hz.IF_ID_RS1 = 5'd3; hz.IF_ID_RS2 = 5'd5; hz.ID_USES_RS2 = 1'b0;
    #1 check("lu_rs2_unused_ctl", ctl, C_DEF);
    tick();
    check("lu_rs2_unused_stall", stall, 32'd1);

    // RS2 matches and is read.
    hz.ID_USES_RS2 = 1'b1;
    #1 check("lu_rs2_ctl", ctl, C_LU);
    tick();
    check("lu_rs2_stall", stall, 32'd2);
    check("lu_rs2_flush", flush, 32'd2);

    // Load into x0 never stalls.
    hz.ID_EX_RD = 5'd0; hz.IF_ID_RS1 = 5'd0; hz.IF_ID_RS2 = 5'd0;
    #1 check("lu_x0_ctl", ctl, C_DEF);
    tick();
    check("lu_x0_stall", stall, 32'd2);

    // Taken branch together with a load-use match: branch wins.
    hz.ID_EX_RD = 5'd5; hz.IF_ID_RS1 = 5'd5; hz.EX_BranchTaken = 1'b1;
    #1 check("br_lu_ctl", ctl, C_BR);
    tick();
    check("br_lu_stall", stall, 32'd2);
    check("br_lu_flush", flush, 32'd3);
    idle();

    // Stray MD_DONE in RUN is ignored.
    hz.MD_DONE = 1'b1;
    #1 check("md_done_stray_ctl", ctl, C_DEF);
    tick();
    check("md_done_stray_state", state, 32'd0);
    idle();

    // Mul/div: start pulse, three wait cycles, done on the fourth.
    hz.ID_EX_IsMD = 1'b1;
    #1 check("md_start_ctl", ctl, C_MDS);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("md_wait_ctl",   ctl,   C_MDW);
      check("md_wait_state", state, 32'd1);
      tick();
    end
    hz.MD_DONE = 1'b1;
    #1;
    check("md_done_ctl",   ctl,   C_DEF);
    check("md_done_state", state, 32'd1);
    tick();
    check("md_end_state", state, 32'd0);
    check("md_end_stall", stall, 32'd6);
    check("md_end_flush", flush, 32'd3);
    hz.ID_EX_IsMD = 1'b0; hz.MD_DONE = 1'b0;
    #1 check("md_after_ctl", ctl, C_DEF);
    tick();

    // Memory wait arriving during MD_WAIT.
    hz.ID_EX_IsMD = 1'b1;
    #1 check("md2_start_ctl", ctl, C_MDS);
    tick();
    #1 check("md2_wait_ctl", ctl, C_MDW);
    tick();
    hz.MEM_Req = 1'b1; hz.MEM_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("mem_wait_ctl", ctl, C_MEM);
      tick();
      check("mem_wait_state", state, 32'd2);
    end
    hz.MEM_Ready = 1'b1; hz.ID_EX_IsMD = 1'b0;
    #1 check("mem_release_ctl", ctl, C_DEF);
    tick();
    check("mem_release_state", state, 32'd0);
    check("mem_release_stall", stall, 32'd11);
    idle();

    // Reset asserted mid-MD_WAIT, between clock edges.
    hz.ID_EX_IsMD = 1'b1;
    tick();
    #1;
    check("pre_rst_state", state, 32'd1);
    check("pre_rst_stall", stall, 32'd12);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", state, 32'd0);
    check("mid_rst_stall", stall, 32'd0);
    check("mid_rst_flush", flush, 32'd0);
    check("mid_rst_ctl",   ctl,   C_RST);
    tick();
    check("held_rst_ctl", ctl, C_RST);
    hz.ID_EX_IsMD = 1'b0;
    rst_n = 1'b1;
    #1 check("post_rst_ctl", ctl, C_DEF);
    tick();
    check("post_rst_state", state, 32'd0);

    // 2-bit counters: five consecutive stall cycles saturate at 3.
    hz2.ID_EX_RD = 5'd7; hz2.ID_EX_MemRead = 1'b1;
    hz2.IF_ID_RS2 = 5'd7; hz2.ID_USES_RS2 = 1'b1;
    #1 check("sat_ctl", ctl2, C_LU);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("sat_stall", stall2, (i < 3) ? i : 3);
      check("sat_flush", flush2, (i < 3) ? i : 3);
    end
    idle2();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter CNT_W, default 16, width of each saturating performance counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 IF_ID_RS1 / IF_ID_RS2  input  5 each  source registers of instruction in ID.
REQ-005 ID_USES_RS1 / ID_USES_RS2  input  1 each  ID instruction actually reads RS1 / RS2.
REQ-006 ID_EX_RD  input  5  destination of instruction in EX; ID_EX_MemRead  input  1  EX instruction is a load.
REQ-007 ID_EX_IsMD  input  1  EX instruction is multi-cycle mul/div; MD_DONE  input  1  mul/div result valid this cycle.
REQ-008 EX_BranchTaken  input  1  EX resolved a taken branch/jump this cycle.
REQ-009 MEM_Req  input  1  MEM-stage instruction accesses data memory; MEM_Ready  input  1  data memory completes this cycle.
REQ-010 PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write  output  1 each  pipeline-register load enables.
REQ-011 IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush  output  1 each  insert bubble (NOP) into that register.
REQ-012 MD_START  output  1  one-cycle start pulse to mul/div unit.
REQ-013 STATE  output  2  current FSM state; STALL_CNT, FLUSH_CNT  output  CNT_W each  performance counters.

Function
REQ-014 FSM states SHALL be RUN=00, MD_WAIT=01, MEM_WAIT=10; 11 unused, SHALL return to RUN next cycle.
REQ-015 Default (no hazard): all Write=1, all Flush=0, MD_START=0.
REQ-016 Memory wait: when MEM_Req=1 and MEM_Ready=0 in any state, all Write=0 and MEM_WB_Flush=1 that same cycle; next state MEM_WAIT; stays until cycle with MEM_Ready=1, then RUN. Highest priority.
REQ-017 Mul/div: in RUN with ID_EX_IsMD=1 and md_issued=0, MD_START=1 for one cycle, md_issued set, next state MD_WAIT.
REQ-018 In MD_WAIT (and MD_START cycle): PC_Write=IF_ID_Write=ID_EX_Write=0, EX_MEM_Flush=1; on MD_DONE=1 cycle EX_MEM_Write=1, EX_MEM_Flush=0, others released, next RUN, md_issued cleared.
REQ-019 md_issued SHALL prevent re-issue of the same EX instruction; cleared whenever ID_EX_Write=1.
REQ-020 Load-use: in RUN, ID_EX_MemRead=1, ID_EX_RD!=0 and RD matches a used IF_ID_RS1/RS2 -> PC_Write=IF_ID_Write=0, ID_EX_Flush=1 for exactly one cycle.
REQ-021 Branch: in RUN, EX_BranchTaken=1 -> IF_ID_Flush=ID_EX_Flush=1, PC_Write=1; overrides load-use in same cycle.
REQ-022 Priority: memory wait > mul/div > branch > load-use; lower-priority event in a frozen cycle is re-evaluated next cycle from held inputs.
REQ-023 STALL_CNT increments every cycle PC_Write=0 with rst_n high; FLUSH_CNT increments every cycle IF_ID_Flush or ID_EX_Flush=1; both saturate at all-ones, never wrap.
REQ-024 MD_DONE outside MD_WAIT/MD_START cycle SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately force STATE=RUN, md_issued=0, STALL_CNT=FLUSH_CNT=0, MD_START=0, all Write=0, all Flush=1, independent of clk.
REQ-026 Reset asserted mid-MD_WAIT or MEM_WAIT SHALL abandon the wait; after deassertion FSM starts in RUN with default outputs.

Structure
REQ-027 Shared package hazard_pkg SHALL hold state encodings (RUN, MD_WAIT, MEM_WAIT) and NOP-related constants.
REQ-028 One sub-module sat_counter (parameter width, inc, async active-low reset) SHALL be instantiated twice for STALL_CNT and FLUSH_CNT.

Verification
REQ-029 Load x5 in EX (ID_EX_RD=5, MemRead=1), ID reads RS1=5 -> one cycle PC_Write=0, ID_EX_Flush=1, STALL_CNT 0->1.
REQ-030 Same as REQ-029 with ID_EX_RD=0 -> no stall, all Write=1.
REQ-031 ID_EX_IsMD=1, MD_DONE after 4 cycles -> MD_START single pulse, STATE=01 for 4 cycles, EX_MEM_Write=1 on done cycle, no second MD_START.
REQ-032 EX_BranchTaken=1 with simultaneous load-use match -> IF_ID_Flush=ID_EX_Flush=1, PC_Write=1, FLUSH_CNT+1, STALL_CNT unchanged.
REQ-033 MEM_Req=1, MEM_Ready=0 for 3 cycles during MD_WAIT -> all Write=0, MEM_WB_Flush=1, STATE=10, returns RUN when Ready=1.
REQ-034 rst_n pulsed low mid-MD_WAIT; CNT_W=2 with 5 stalls -> STATE=00 and counters 0 immediately; counter saturates at 3.
